// File: rtl/hazard_unit_n.sv
// Forwarding select, stall and flush control for the ID stage.
// One scan instance per ID source operand; a 3-state FSM sequences cache freezes and deferred flushes.

module hazard_unit_n_fwd #(
   parameter int NSTG = 4,
   parameter int AW   = 5,
   parameter int SELW = 3
) (
   input  logic [NSTG*AW-1:0] stg_rd,
   input  logic [NSTG-1:0]    stg_wr,
   input  logic [NSTG-1:0]    stg_ready,
   input  logic [AW-1:0]      src,
   output logic [SELW-1:0]    sel,
   output logic               pend
);
   logic [NSTG-1:0] hit;

   for (genvar k = 0; k < NSTG; k++) begin : g_hit
      assign hit[k] = stg_wr[k] && (stg_rd[k*AW +: AW] != '0) && (stg_rd[k*AW +: AW] == src);
   end

   // Scan oldest to youngest so the youngest matching stage overwrites last.
   always_comb begin
      sel  = '0;
      pend = 1'b0;
      for (int k = NSTG-1; k >= 0; k--) begin
         if (hit[k]) begin
            sel  = stg_ready[k] ? SELW'(k+1) : '0;
            pend = ~stg_ready[k];
         end
      end
   end
endmodule

module hazard_unit_n #(
   parameter int NSTG = 4,
   parameter int AW   = 5,
   parameter int SELW = 3,
   parameter int CNTW = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NSTG*AW-1:0] stg_rd,
   input  logic [NSTG-1:0]   stg_wr,
   input  logic [NSTG-1:0]   stg_ready,
   input  logic [AW-1:0]     id_rs,
   input  logic [AW-1:0]     id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic              id_hilo_use,
   input  logic              mdu_busy,
   input  logic              icache_data_ok,
   input  logic              dcache_addr_ok,
   input  logic              dcache_data_ok,
   input  logic              mem1_dcache_en,
   input  logic              mem2_dcache_en,
   input  logic              flush_req,
   output logic [SELW-1:0]   fwd_rs_sel,
   output logic [SELW-1:0]   fwd_rt_sel,
   output logic              pc_we,
   output logic              if_we,
   output logic              id_we,
   output logic              id_bubble,
   output logic              back_we,
   output logic              flush_out,
   output logic              is_stall,
   output logic              mem_last_stall,
   output logic [CNTW-1:0]   stall_cnt
);
   typedef enum logic [1:0] {RUN, MEMWAIT, FLUSHWAIT} state_t;

   state_t state, nxt;

   logic [1:0][AW-1:0]   src;
   logic [1:0][SELW-1:0] sel;
   logic [1:0]           pend;

   assign src = {id_rt, id_rs};

   for (genvar i = 0; i < 2; i++) begin : g_op
      hazard_unit_n_fwd #(.NSTG(NSTG), .AW(AW), .SELW(SELW)) u_fwd (
         .stg_rd    (stg_rd),
         .stg_wr    (stg_wr),
         .stg_ready (stg_ready),
         .src       (src[i]),
         .sel       (sel[i]),
         .pend      (pend[i])
      );
   end

   assign fwd_rs_sel = sel[0];
   assign fwd_rt_sel = sel[1];

   logic data_haz, mdu_haz, mem_stall, data_ok;

   assign data_haz  = (id_use_rs & pend[0]) | (id_use_rt & pend[1]);
   assign mdu_haz   = mdu_busy & id_hilo_use;
   assign mem_stall = (mem2_dcache_en & ~dcache_data_ok)
                    | (mem1_dcache_en & ~dcache_addr_ok) | ~icache_data_ok;
   assign data_ok   = ~mem2_dcache_en | dcache_data_ok;

   always_comb begin
      pc_we     = 1'b0;
      if_we     = 1'b0;
      id_we     = 1'b0;
      back_we   = 1'b0;
      id_bubble = 1'b0;
      flush_out = 1'b0;
      nxt       = state;
      if (rst) begin
         nxt = RUN;
      end else begin
         case (state)
            RUN, MEMWAIT: begin
               if (flush_req) begin
                  // Front end may restart now; the back end holds until MEM2 data lands.
                  {pc_we, if_we, id_we} = 3'b111;
                  flush_out = 1'b1;
                  back_we   = data_ok;
                  nxt       = data_ok ? RUN : FLUSHWAIT;
               end else if (mem_stall) begin
                  id_bubble = 1'b1;
                  nxt       = MEMWAIT;
               end else if (data_haz | mdu_haz) begin
                  id_we     = 1'b1;
                  back_we   = 1'b1;
                  id_bubble = 1'b1;
                  nxt       = RUN;
               end else begin
                  {pc_we, if_we, id_we, back_we} = 4'b1111;
                  nxt = RUN;
               end
            end
            FLUSHWAIT: begin
               flush_out = 1'b1;
               back_we   = data_ok;
               nxt       = data_ok ? RUN : FLUSHWAIT;
            end
            default: nxt = RUN;
         endcase
      end
   end

   assign is_stall = ~rst & ~pc_we & ~flush_out;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= RUN;
         mem_last_stall <= 1'b0;
         stall_cnt      <= '0;
      end else begin
         state          <= nxt;
         mem_last_stall <= (nxt == MEMWAIT);
         if (~pc_we && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_hazard_unit_n.sv
// Directed-vector bench for hazard_unit_n; expected values are hand-derived.

module tb_hazard_unit_n;
   localparam int NSTG = 4, AW = 5, SELW = 3, CNTW = 32;

   logic clk = 1'b0;
   logic rst;
   logic [NSTG*AW-1:0] stg_rd;
   logic [NSTG-1:0] stg_wr, stg_ready;
   logic [AW-1:0] id_rs, id_rt;
   logic id_use_rs, id_use_rt, id_hilo_use, mdu_busy;
   logic icache_data_ok, dcache_addr_ok, dcache_data_ok;
   logic mem1_dcache_en, mem2_dcache_en, flush_req;
   logic [SELW-1:0] fwd_rs_sel, fwd_rt_sel;
   logic pc_we, if_we, id_we, id_bubble, back_we, flush_out, is_stall, mem_last_stall;
   logic [CNTW-1:0] stall_cnt;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   hazard_unit_n #(.NSTG(NSTG), .AW(AW), .SELW(SELW), .CNTW(CNTW)) dut (
      .clk(clk), .rst(rst), .stg_rd(stg_rd), .stg_wr(stg_wr), .stg_ready(stg_ready),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_hilo_use(id_hilo_use), .mdu_busy(mdu_busy), .icache_data_ok(icache_data_ok),
      .dcache_addr_ok(dcache_addr_ok), .dcache_data_ok(dcache_data_ok),
      .mem1_dcache_en(mem1_dcache_en), .mem2_dcache_en(mem2_dcache_en),
      .flush_req(flush_req), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
      .pc_we(pc_we), .if_we(if_we), .id_we(id_we), .id_bubble(id_bubble),
      .back_we(back_we), .flush_out(flush_out), .is_stall(is_stall),
      .mem_last_stall(mem_last_stall), .stall_cnt(stall_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Advance one cycle, then settle combinational outputs away from the edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst = 1'b1; stg_rd = '0; stg_wr = '0; stg_ready = '0;
      id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
      id_hilo_use = 1'b0; mdu_busy = 1'b0; icache_data_ok = 1'b1;
      dcache_addr_ok = 1'b1; dcache_data_ok = 1'b1; mem1_dcache_en = 1'b0;
      mem2_dcache_en = 1'b0; flush_req = 1'b0;
      tick(); tick();
      check("rst_pc_we", pc_we, 0);
      check("rst_back_we", back_we, 0);
      check("rst_flush_out", flush_out, 0);
      check("rst_is_stall", is_stall, 0);
      check("rst_cnt", stall_cnt, 0);
      check("rst_last_stall", mem_last_stall, 0);
      rst = 1'b0; #1;

      // EX and MEM1 both write r5 (EX wins); MEM2 writes r7
      stg_rd = {5'd0, 5'd7, 5'd5, 5'd5}; stg_wr = 4'b0111; stg_ready = 4'b0111;
      id_rs = 5'd5; id_rt = 5'd7; id_use_rs = 1'b1; id_use_rt = 1'b1; #1;
      check("fwd_rs_ex", fwd_rs_sel, 1);
      check("fwd_rt_mem2", fwd_rt_sel, 3);
      check("fwd_pc_we", pc_we, 1);
      check("fwd_bubble", id_bubble, 0);

      // EX not ready: youngest match still owns the operand -> stall
      stg_ready = 4'b0110; #1;
      check("pend_sel", fwd_rs_sel, 0);
      check("pend_bubble", id_bubble, 1);
      check("pend_pc_we", pc_we, 0);
      check("pend_id_we", id_we, 1);
      check("pend_back_we", back_we, 1);
      check("pend_is_stall", is_stall, 1);
      tick();
      stg_ready = 4'b0111; #1;
      check("ready_sel", fwd_rs_sel, 1);
      check("ready_pc_we", pc_we, 1);
      check("cnt_after_haz", stall_cnt, 1);

      // HI/LO busy
      stg_wr = '0; mdu_busy = 1'b1; id_hilo_use = 1'b1; #1;
      check("mdu_pc_we", pc_we, 0);
      check("mdu_bubble", id_bubble, 1);
      tick();
      check("cnt_after_mdu", stall_cnt, 2);
      mdu_busy = 1'b0; id_hilo_use = 1'b0;

      // r0 is never forwarded nor a hazard
      stg_rd = '0; stg_wr = 4'b1111; stg_ready = 4'b0000; id_rs = '0; id_rt = '0; #1;
      check("r0_rs_sel", fwd_rs_sel, 0);
      check("r0_rt_sel", fwd_rt_sel, 0);
      check("r0_pc_we", pc_we, 1);
      stg_wr = '0;

      // Clear counter, then 3-cycle dcache freeze
      rst = 1'b1; tick(); rst = 1'b0; #1;
      check("cnt_cleared", stall_cnt, 0);
      mem2_dcache_en = 1'b1; dcache_data_ok = 1'b0; #1;
      check("mw1_pc_we", pc_we, 0);
      check("mw1_back_we", back_we, 0);
      check("mw1_bubble", id_bubble, 1);
      check("mw1_last", mem_last_stall, 0);
      tick();
      check("mw2_last", mem_last_stall, 1);
      check("mw2_id_we", id_we, 0);
      tick();
      check("mw3_last", mem_last_stall, 1);
      check("mw3_if_we", if_we, 0);
      tick();
      dcache_data_ok = 1'b1; #1;
      check("mw4_last", mem_last_stall, 1);
      check("mw4_pc_we", pc_we, 1);
      check("mw4_cnt", stall_cnt, 3);
      tick();
      check("mw5_last", mem_last_stall, 0);

      // Flush with MEM2 data outstanding for two cycles; flush_req held to show it is ignored
      dcache_data_ok = 1'b0; flush_req = 1'b1; #1;
      check("fl1_flush", flush_out, 1);
      check("fl1_back_we", back_we, 0);
      check("fl1_pc_we", pc_we, 1);
      tick();
      check("fl2_flush", flush_out, 1);
      check("fl2_back_we", back_we, 0);
      check("fl2_pc_we", pc_we, 0);
      check("fl2_is_stall", is_stall, 0);
      tick();
      dcache_data_ok = 1'b1; #1;
      check("fl3_flush", flush_out, 1);
      check("fl3_back_we", back_we, 1);
      check("fl3_pc_we", pc_we, 0);
      tick();
      flush_req = 1'b0; #1;
      check("fl4_flush", flush_out, 0);
      check("fl4_pc_we", pc_we, 1);

      // Flush beats a pending freeze in MEMWAIT
      icache_data_ok = 1'b0; #1;
      check("mwf_pc_we", pc_we, 0);
      tick();
      check("mwf_last", mem_last_stall, 1);
      flush_req = 1'b1; #1;
      check("mwf_flush", flush_out, 1);
      check("mwf_back_we", back_we, 1);
      check("mwf_pc_we2", pc_we, 1);
      tick();
      flush_req = 1'b0; icache_data_ok = 1'b1; #1;
      check("mwf_run", flush_out, 0);
      check("mwf_last2", mem_last_stall, 0);

      // Reset in FLUSHWAIT
      dcache_data_ok = 1'b0; flush_req = 1'b1; tick();
      flush_req = 1'b0; #1;
      check("rfw_in_wait", flush_out, 1);
      rst = 1'b1; #1;
      check("rfw_rst_flush", flush_out, 0);
      check("rfw_rst_pc_we", pc_we, 0);
      tick();
      rst = 1'b0; #1;
      check("rfw_flush", flush_out, 0);
      check("rfw_cnt", stall_cnt, 0);
      check("rfw_bubble", id_bubble, 1);
      check("rfw_is_stall", is_stall, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
